// File: rtl/dcache_uncache_ctrl.sv
// Purpose: single-beat uncached load/store engine between the dcache bypass path and an AXI4-Lite-style bus.
// Latency: load/store respond 3 cycles after acceptance with bus readies high; a misaligned access responds in 1 cycle.
// Backpressure: one request in flight; req_ready is high only in IDLE, and bus channels wait indefinitely on their readies.
module dcache_uncache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [2:0]        ar_size,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [2:0]        aw_size,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic [7:0]        w_strb,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [1:0]        b_resp
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_AR  = 3'd1;
  localparam logic [2:0] RD_R   = 3'd2;
  localparam logic [2:0] WR_REQ = 3'd3;
  localparam logic [2:0] WR_B   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        strb_q;
  logic              aw_done;
  logic              w_done;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [2:0]        align_mask;
  logic              misaligned;
  logic [7:0]        strb_base;
  logic [DATA_W-1:0] rd_mask;
  logic [DATA_W-1:0] rd_data;
  logic              aw_fin;
  logic              w_fin;

  // Request decode: alignment check, byte strobes, and read-lane extraction.
  always_comb begin
    align_mask = 3'd0;
    strb_base  = 8'h01;
    rd_mask    = DATA_W'(64'h0000_0000_0000_00FF);
    case (req_size)
      2'd0:    begin align_mask = 3'd0; strb_base = 8'h01; end
      2'd1:    begin align_mask = 3'd1; strb_base = 8'h03; end
      2'd2:    begin align_mask = 3'd3; strb_base = 8'h0F; end
      default: begin align_mask = 3'd7; strb_base = 8'hFF; end
    endcase
    case (size_q)
      2'd0:    rd_mask = DATA_W'(64'h0000_0000_0000_00FF);
      2'd1:    rd_mask = DATA_W'(64'h0000_0000_0000_FFFF);
      2'd2:    rd_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
      default: rd_mask = DATA_W'(64'hFFFF_FFFF_FFFF_FFFF);
    endcase
    misaligned = |(req_addr[2:0] & align_mask);
    rd_data    = (r_data >> {addr_q[2:0], 3'b000}) & rd_mask;
    // A channel counts as done once its handshake has happened, now or earlier.
    aw_fin     = aw_done | aw_ready;
    w_fin      = w_done  | w_ready;
  end

  // Main FSM plus the request/response holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= 2'd0;
      wdata_q <= '0;
      strb_q  <= 8'h00;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata << {req_addr[2:0], 3'b000};
            strb_q  <= strb_base << req_addr[2:0];
            if (misaligned) begin
              // Never touches the bus; report the error straight away.
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= DONE;
            end else begin
              state <= req_wen ? WR_REQ : RD_AR;
            end
          end
        end
        RD_AR: begin
          if (ar_ready) state <= RD_R;
        end
        RD_R: begin
          if (r_valid) begin
            err_q   <= |r_resp;
            rdata_q <= (|r_resp) ? '0 : rd_data;
            state   <= DONE;
          end
        end
        WR_REQ: begin
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_B;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        WR_B: begin
          if (b_valid) begin
            err_q   <= |b_resp;
            rdata_q <= '0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode from registered state, so bus inputs never reach a valid combinationally.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign ar_valid   = (state == RD_AR);
  assign ar_addr    = addr_q;
  assign ar_size    = {1'b0, size_q};
  assign r_ready    = (state == RD_R);
  assign aw_valid   = (state == WR_REQ) && !aw_done;
  assign aw_addr    = addr_q;
  assign aw_size    = {1'b0, size_q};
  assign w_valid    = (state == WR_REQ) && !w_done;
  assign w_data     = wdata_q;
  assign w_strb     = strb_q;
  assign b_ready    = (state == WR_B);

endmodule

// File: tb/tb_dcache_uncache_ctrl.sv
// Directed bench for dcache_uncache_ctrl: loads, stores, misalignment, bus errors, back-to-back and mid-flight reset.
// Inputs are driven 1ns after the rising edge and outputs sampled there, away from the active edge.
// A passive monitor counts handshakes and response pulses so totals can be compared per scenario.
module tb_dcache_uncache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size;
  logic        r_valid, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic [2:0]  aw_size;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;

  int n_chk  = 0;
  int n_pass = 0;

  int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_resp = 0, n_arv = 0, n_wv = 0, n_acc = 0;

  always #5 clk = ~clk;

  dcache_uncache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_size(ar_size),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_size(aw_size),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  // Passive monitor: counts handshakes and pulses as seen at each rising edge.
  always @(posedge clk) begin
    if (ar_valid && ar_ready)   n_ar++;
    if (aw_valid && aw_ready)   n_aw++;
    if (w_valid && w_ready)     n_w++;
    if (b_valid && b_ready)     n_b++;
    if (resp_valid)             n_resp++;
    if (ar_valid)               n_arv++;
    if (w_valid)                n_wv++;
    if (req_valid && req_ready) n_acc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%h expected=0x%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic [31:0] addr, input logic wen, input logic [1:0] size,
                       input logic [63:0] wdata);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wen   = wen;
    req_size  = size;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  // Step until resp_valid is seen, with a cycle budget; cyc is the cycle index since acceptance.
  task automatic wait_resp(input int start, input int max, output int cyc);
    cyc = start;
    while (resp_valid !== 1'b1 && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int s_ar, s_aw, s_w, s_b, s_resp, s_arv, s_wv, s_acc;
    logic stable;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_size = 2'd0; req_wdata = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'd0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'd0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_req_ready",  req_ready,  1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err",   resp_err,   0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_bus_valids", {ar_valid, aw_valid, w_valid}, 0);
    chk("rst_bus_readies", {r_ready, b_ready}, 0);

    // Aligned 4B load, readies high
    ar_ready = 1'b1; r_valid = 1'b1; r_data = 64'h1234_5678_9ABC_DEF0; r_resp = 2'd0;
    issue(32'hA000_0004, 1'b0, 2'd2, '0);
    chk("ld4_ar_valid", ar_valid, 1);
    chk("ld4_ar_addr",  ar_addr,  32'hA000_0004);
    chk("ld4_ar_size",  ar_size,  3'd2);
    chk("ld4_req_ready_busy", req_ready, 0);
    wait_resp(1, 20, cyc);
    chk("ld4_latency", cyc, 3);
    chk("ld4_rdata", resp_rdata, 64'h0000_0000_1234_5678);
    chk("ld4_err",   resp_err,   0);
    tick();
    chk("ld4_pulse_one_cycle", resp_valid, 0);
    ar_ready = 1'b0; r_valid = 1'b0;

    // 1B store with AW accepted 3 cycles after W
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_resp = n_resp;
    w_ready = 1'b1; aw_ready = 1'b0; b_valid = 1'b1; b_resp = 2'd0;
    issue(32'h1000_0003, 1'b1, 2'd0, 64'hA5);
    chk("st1_aw_w_together", {aw_valid, w_valid}, 2'b11);
    chk("st1_w_data", w_data, 64'h0000_0000_A500_0000);
    chk("st1_w_strb", w_strb, 8'h08);
    chk("st1_aw_addr", aw_addr, 32'h1000_0003);
    tick();
    chk("st1_w_dropped_aw_held", {aw_valid, w_valid}, 2'b10);
    tick(); tick();
    aw_ready = 1'b1;
    tick();
    aw_ready = 1'b0;
    chk("st1_b_ready", b_ready, 1);
    chk("st1_aw_dropped", aw_valid, 0);
    wait_resp(5, 20, cyc);
    chk("st1_latency", cyc, 6);
    chk("st1_rdata_zero", resp_rdata, 0);
    chk("st1_err", resp_err, 0);
    tick(); tick();
    chk("st1_handshakes", {n_aw - s_aw, n_w - s_w, n_b - s_b, n_resp - s_resp}, {32'd1, 32'd1, 32'd1, 32'd1} >> 0 == 0 ? 0 : {32'd1, 32'd1});
    chk("st1_aw_count",   n_aw - s_aw, 1);
    chk("st1_w_count",    n_w - s_w, 1);
    chk("st1_b_count",    n_b - s_b, 1);
    chk("st1_resp_count", n_resp - s_resp, 1);
    w_ready = 1'b0; b_valid = 1'b0;

    // Misaligned 2B load: no bus activity
    s_arv = n_arv;
    ar_ready = 1'b1; r_valid = 1'b1;
    issue(32'h0F00_0001, 1'b0, 2'd1, '0);
    chk("mis_resp_valid_c1", resp_valid, 1);
    chk("mis_err", resp_err, 1);
    chk("mis_rdata", resp_rdata, 0);
    tick(); tick(); tick();
    chk("mis_no_ar_valid", n_arv - s_arv, 0);
    ar_ready = 1'b0; r_valid = 1'b0;

    // Bus error read with AR stalled 5 cycles
    r_valid = 1'b1; r_data = 64'hFFFF_EEEE_DDDD_CCCC; r_resp = 2'b10;
    issue(32'h0F00_0010, 1'b0, 2'd3, '0);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (ar_valid !== 1'b1 || ar_addr !== 32'h0F00_0010) stable = 1'b0;
      if (i < 4) tick();
    end
    chk("rderr_ar_stable", stable, 1);
    ar_ready = 1'b1;
    wait_resp(5, 30, cyc);
    chk("rderr_resp_valid", resp_valid, 1);
    chk("rderr_err", resp_err, 1);
    chk("rderr_rdata", resp_rdata, 0);
    tick(); tick();
    chk("rderr_err_held", resp_err, 1);
    r_resp = 2'b00;

    // Back-to-back with req_valid held high
    r_data = 64'h1122_3344_5566_7788;
    s_acc = n_acc; s_resp = n_resp;
    req_valid = 1'b1; req_addr = 32'hA000_0008; req_wen = 1'b0; req_size = 2'd3;
    chk("b2b_ready_c0", req_ready, 1);
    tick();
    chk("b2b_busy_c1", req_ready, 0);
    tick();
    chk("b2b_busy_c2", req_ready, 0);
    tick();
    chk("b2b_busy_c3", req_ready, 0);
    chk("b2b_resp1", resp_valid, 1);
    chk("b2b_rdata1", resp_rdata, 64'h1122_3344_5566_7788);
    chk("b2b_err1_cleared", resp_err, 0);
    tick();
    chk("b2b_idle_c4", req_ready, 1);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("b2b_resp2_c7", resp_valid, 1);
    tick();
    chk("b2b_accepts", n_acc - s_acc, 2);
    chk("b2b_resps", n_resp - s_resp, 2);

    // Reset while waiting in RD_R
    r_valid = 1'b0;
    issue(32'hA000_0020, 1'b0, 2'd2, '0);
    tick();
    chk("rst_mid_r_ready", r_ready, 1);
    s_resp = n_resp;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_drop", {ar_valid, aw_valid, w_valid, r_ready, b_ready, resp_valid}, 0);
    r_valid = 1'b1;
    tick(); tick(); tick();
    chk("rst_mid_no_resp", n_resp - s_resp, 0);
    rst_n = 1'b1;
    tick();
    s_wv = n_wv; s_ar = n_ar;
    r_data = 64'hDEAD_BEEF_CAFE_F00D;
    issue(32'hA000_0000, 1'b0, 2'd3, '0);
    wait_resp(1, 20, cyc);
    chk("post_rst_latency", cyc, 3);
    chk("post_rst_rdata", resp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    chk("post_rst_err", resp_err, 0);
    tick();
    chk("post_rst_no_w", n_wv - s_wv, 0);
    chk("post_rst_one_ar", n_ar - s_ar, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dcache_uncache_ctrl.md
Name: dcache_uncache_ctrl

Overview:
Executes single-beat uncached loads and stores on behalf of the dcache once an access has been classified as uncached (MMIO windows 0x0F00_0000–0x0FFF_FFFF, 0x1000_0000–0x1000_0FFF and 0xA000_0000–0xBFFF_FFFF).
Accepts one request at a time from the dcache/LSU side and issues an AXI4-Lite-style read (AR/R) or write (AW/W/B) transaction.
Returns read data that is lane-shifted and zero-extended, or a write completion, as a one-cycle response pulse.
Sits between the dcache miss/bypass path and the memory-side bus arbiter.

Parameters:
ADDR_W, 32, request/bus address width
DATA_W, 64, data width; fixed at 64 (byte offset = addr[2:0])

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  uncached request present
req_ready  out  1  block can accept a request
req_addr  in  ADDR_W  byte address
req_wen  in  1  1 = store, 0 = load
req_size  in  2  log2 of byte count: 0=1B, 1=2B, 2=4B, 3=8B
req_wdata  in  DATA_W  store data, LSB-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  load data, LSB-aligned, zero-extended
resp_err  out  1  bus error or misaligned access
ar_valid/ar_ready  out/in  1/1  read address handshake
ar_addr  out  ADDR_W  read address, the latched req_addr
ar_size  out  3  {1'b0,req_size}
r_valid/r_ready  in/out  1/1  read data handshake
r_data  in  DATA_W  read data, lane-aligned
r_resp  in  2  read response
aw_valid/aw_ready  out/in  1/1  write address handshake
aw_addr  out  ADDR_W  latched req_addr
aw_size  out  3  {1'b0,req_size}
w_valid/w_ready  out/in  1/1  write data handshake
w_data  out  DATA_W  req_wdata << (addr[2:0]*8)
w_strb  out  8  ((1<<(1<<size))-1) << addr[2:0]
b_valid/b_ready  in/out  1/1  write response handshake
b_resp  in  2  write response

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All bus valids/readies = 0; resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - req_ready = 1 after reset release.
  - Asserting reset mid-transaction abandons it immediately; no response is emitted.
- States: IDLE, RD_AR, RD_R, WR_REQ, WR_B, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr/wen/size/wdata.
  - Misalignment check: addr[2:0] & ((1<<size)-1) != 0. If misaligned, set err = 1 and go to DONE with no bus activity.
  - Otherwise go to RD_AR (load) or WR_REQ (store).
- RD_AR:
  - ar_valid = 1, held with stable ar_addr until ar_ready.
  - On ar_valid & ar_ready, go to RD_R.
- RD_R:
  - r_ready = 1.
  - On r_valid, latch rdata = (r_data >> addr[2:0]*8), masked to (1<<size) bytes.
  - Latch err = (r_resp != 0), then go to DONE.
- WR_REQ:
  - aw_valid and w_valid start high together.
  - Each drops independently after its own handshake; completion is tracked by flags aw_done/w_done.
  - Either order, or both in the same cycle, is legal.
  - When both are done, clear the flags and go to WR_B.
- WR_B:
  - b_ready = 1.
  - On b_valid, err = (b_resp != 0), then go to DONE.
- DONE:
  - resp_valid = 1 for exactly one cycle; resp_rdata/resp_err are valid that cycle.
  - resp_rdata = 0 for stores and errors.
  - req_ready = 0; return to IDLE next cycle.
  - resp_err and resp_rdata hold until the next DONE.
- req_ready = 1 only in IDLE. Requests are never accepted in DONE, so there is no overlap.
- Minimum latency with bus readies tied high:
  - Load: accept at cycle 0, AR at cycle 1, R at cycle 2, resp_valid at cycle 3.
  - Store: same, with AW/W at cycle 1 and B at cycle 2.
  - Misaligned: resp_valid at cycle 1.
- Registered outputs only; no combinational path from bus inputs to bus valids.
- 8-byte accesses require addr[2:0] = 0; their w_strb is 0xFF.

Test Plan:
- Aligned 4B load at 0xA000_0004, slave r_data=0x1234_5678_9ABC_DEF0, readies high:
  - ar_addr=0xA000_0004, ar_size=2.
  - resp_rdata=0x0000_0000_1234_5678, resp_err=0; resp_valid at cycle 3.
- 1B store at 0x1000_0003, req_wdata=0xA5:
  - w_data=0x0000_0000_A500_0000, w_strb=0x08.
  - With aw_ready delayed 3 cycles after w_ready, exactly one AW and one W handshake occur, then B, then one resp_valid.
- Misaligned 2B load at 0x0F00_0001:
  - resp_valid at cycle 1, resp_err=1.
  - No ar_valid ever asserted.
- Read with r_resp=2'b10 and ar_ready held low for 5 cycles:
  - ar_valid and ar_addr stay stable for all 5 cycles.
  - resp_err=1, resp_rdata=0.
- Back-to-back requests with req_valid held high:
  - req_ready is low during the whole transaction.
  - The second request is accepted only in the IDLE cycle after DONE; two responses are produced.
- rst_n pulsed low while in RD_R:
  - All valids/readies drop asynchronously and no resp_valid occurs.
  - A fresh 8B load at 0xA000_0000 completes normally with w_strb unused and rdata equal to the full 64-bit r_data.
